// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stage indices and vector type for the pipeline hazard controller.
package pipe_stall_ctrl_pkg;

  localparam int NUM_STAGES_DEF = 5;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef logic [NUM_STAGES_DEF-1:0] stage_vec_t;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_stall_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_r;

  // Count register: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Resolves per-stage stall/flush requests into advance enables and owns
// the per-stage valid bits plus bubble/flush perf counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter bit COLLAPSE   = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  input  logic                  cnt_clr,
  output logic [NUM_STAGES-1:0] adv,
  output logic [NUM_STAGES-1:0] valid,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic [NUM_STAGES-1:0] hold_s;
  logic [NUM_STAGES-1:0] fl_s;
  logic [NUM_STAGES-1:0] kill_s;
  logic [NUM_STAGES-1:0] valid_nxt_s;
  logic [NUM_STAGES-1:0] valid_r;

  // A flush from an empty stage carries no instruction and is ignored.
  assign fl_s = flush_req & valid_r;

  // Hold chain from writeback upward; an invalid stage absorbs back-pressure when collapsing.
  always_comb begin
    hold_s                 = {NUM_STAGES{1'b0}};
    hold_s[NUM_STAGES-1]   = stall_req[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      hold_s[i] = stall_req[i] | (hold_s[i+1] & (valid_r[i+1] | !COLLAPSE));
    end
  end

  // Kill is the prefix-OR of honoured flushes in strictly older stages.
  always_comb begin
    kill_s               = {NUM_STAGES{1'b0}};
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      kill_s[i] = kill_s[i+1] | fl_s[i+1];
    end
  end

  // Valid next-state: kill beats hold; an advancing stage behind a held one gets a bubble.
  always_comb begin
    valid_nxt_s         = valid_r;
    valid_nxt_s[STG_IF] = kill_s[STG_IF] ? 1'b0 : (hold_s[STG_IF] ? valid_r[STG_IF] : 1'b1);
    for (int i = 1; i < NUM_STAGES; i++) begin
      valid_nxt_s[i] = kill_s[i] ? 1'b0 :
                       (hold_s[i] ? valid_r[i] :
                        (valid_r[i-1] & ~hold_s[i-1] & ~kill_s[i-1]));
    end
  end

  // Per-stage valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {NUM_STAGES{1'b0}};
    end else begin
      valid_r <= valid_nxt_s;
    end
  end

  assign adv   = ~hold_s;
  assign valid = valid_r;

  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (~valid_r[NUM_STAGES-1]),
    .cnt   (bubble_cnt)
  );

  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (|fl_s),
    .cnt   (flush_cnt)
  );

endmodule
